// File: rtl/jtopl_pkg.sv
// Shared constants for the OPL LFO slice.
// Counter widths, tremolo triangle geometry and output widths.
package jtopl_pkg;

  localparam int LFO_CNT_W  = 13;
  localparam int TR_STEPS   = 210;
  localparam int TR_PEAK    = 104;
  localparam int TR_PRESC_W = 6;
  localparam int AM_W       = 5;
  localparam int TR_W       = 8;
  localparam int VIB_W      = 3;

  localparam int AM_SH_DEEP = 2;
  localparam int AM_SH_SHAL = 4;

endpackage

// File: rtl/jtopl_lfo_am.sv
// Tremolo level from triangle position; combinational only.
// Shared with the envelope-stage bench.
module jtopl_lfo_am
  import jtopl_pkg::*;
(
  input  logic [TR_W-1:0] tr_pos,
  input  logic            am_dep,
  output logic [AM_W-1:0] am_level
);

  logic [TR_W-1:0] tri_v;
  logic [TR_W-1:0] sh;
  logic            unused_hi;

  always_comb begin
    tri_v = tr_pos;
    if (tr_pos > TR_W'(TR_PEAK))
      tri_v = TR_W'(TR_STEPS - 1) - tr_pos;
  end

  always_comb begin
    sh = tri_v >> AM_SH_SHAL;
    if (am_dep)
      sh = tri_v >> AM_SH_DEEP;
  end

  assign am_level  = sh[AM_W-1:0];
  assign unused_hi = ^sh[TR_W-1:AM_W];

endmodule

// File: rtl/jtopl_lfo.sv
// OPL LFO: sample counter drives vibrato phase,
// prescaled triangle drives registered tremolo level.
module jtopl_lfo
  import jtopl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cen,
  input  logic             zero,
  input  logic             lfo_clr,
  input  logic             am_dep,
  output logic [VIB_W-1:0] vib_cnt,
  output logic [AM_W-1:0]  am_level
);

  logic                 tick;
  logic                 presc_end;
  logic                 tr_last;
  logic [LFO_CNT_W-1:0] smp_cnt_q, smp_cnt_d;
  logic [TR_W-1:0]      tr_pos_q, tr_pos_d;
  logic [AM_W-1:0]      am_level_q, am_level_d;
  logic [AM_W-1:0]      am_raw;

  assign tick      = cen & zero;
  assign presc_end = &smp_cnt_q[TR_PRESC_W-1:0];
  // Out-of-range positions also fold back to 0
  assign tr_last   = tr_pos_q >= TR_W'(TR_STEPS - 1);

  jtopl_lfo_am u_am (
    .tr_pos   (tr_pos_q),
    .am_dep   (am_dep),
    .am_level (am_raw)
  );

  always_comb begin
    smp_cnt_d  = smp_cnt_q;
    tr_pos_d   = tr_pos_q;
    am_level_d = am_raw;
    if (lfo_clr) begin
      smp_cnt_d  = '0;
      tr_pos_d   = '0;
      am_level_d = '0;
    end else if (tick) begin
      smp_cnt_d = smp_cnt_q + LFO_CNT_W'(1);
      if (presc_end)
        tr_pos_d = tr_last ? '0 : tr_pos_q + TR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_q  <= '0;
      tr_pos_q   <= '0;
      am_level_q <= '0;
    end else if (cen) begin
      smp_cnt_q  <= smp_cnt_d;
      tr_pos_q   <= tr_pos_d;
      am_level_q <= am_level_d;
    end
  end

  assign vib_cnt  = smp_cnt_q[LFO_CNT_W-1 -: VIB_W];
  assign am_level = am_level_q;

endmodule

// File: tb/tb_jtopl_lfo.sv
// Directed and randomised checks for jtopl_lfo.
// Expected values are hand-computed or from a small integer model.
module tb_jtopl_lfo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       cen = 1'b0;
  logic       zero = 1'b0;
  logic       lfo_clr = 1'b0;
  logic       am_dep = 1'b1;
  logic [2:0] vib_cnt;
  logic [4:0] am_level;

  int n_chk = 0;
  int n_err = 0;
  int ntick = 0;

  int m_smp = 0;
  int m_trp = 0;
  int m_am  = 0;

  always #5 clk = ~clk;

  jtopl_lfo dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cen      (cen),
    .zero     (zero),
    .lfo_clr  (lfo_clr),
    .am_dep   (am_dep),
    .vib_cnt  (vib_cnt),
    .am_level (am_level)
  );

  function automatic int lvl(input int p, input bit d);
    int t;
    t = (p < 105) ? p : 209 - p;
    return d ? t / 4 : t / 16;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_smp <= 0;
      m_trp <= 0;
      m_am  <= 0;
    end else if (cen) begin
      if (lfo_clr) begin
        m_smp <= 0;
        m_trp <= 0;
        m_am  <= 0;
      end else begin
        m_am <= lvl(m_trp, am_dep);
        if (zero) begin
          m_smp <= (m_smp + 1) % 8192;
          if (m_smp % 64 == 63)
            m_trp <= (m_trp + 1) % 210;
        end
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d",
               tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic c, input logic z,
                     input logic clr);
    @(negedge clk);
    cen = c;
    zero = z;
    lfo_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic tick_to(input int target, input int gap);
    while (ntick < target) begin
      repeat (gap - 1) cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b1, 1'b0);
      ntick++;
    end
  endtask

  initial begin
    #2 rst_n = 1'b0;
    #1;
    check("rst_vib", 32'(vib_cnt), 0);
    check("rst_am", 32'(am_level), 0);
    check("rst_smp", 32'(dut.smp_cnt_q), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    tick_to(64, 18);
    check("trp_64", 32'(dut.tr_pos_q), 1);
    check("smp_64", 32'(dut.smp_cnt_q), 64);
    tick_to(1023, 18);
    check("vib_1023", 32'(vib_cnt), 0);
    tick_to(1024, 18);
    check("vib_1024", 32'(vib_cnt), 1);

    tick_to(6656, 1);
    check("trp_104", 32'(dut.tr_pos_q), 104);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_104", 32'(am_level), 26);
    am_dep = 1'b0;
    #1;
    check("am_dep_lag", 32'(am_level), 26);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_shal_104", 32'(am_level), 6);
    am_dep = 1'b1;
    cyc(1'b1, 1'b0, 1'b0);
    check("am_deep_back", 32'(am_level), 26);

    tick_to(6720, 1);
    check("trp_105", 32'(dut.tr_pos_q), 105);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_105", 32'(am_level), 26);
    tick_to(6976, 1);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_109", 32'(am_level), 25);

    tick_to(8191, 1);
    check("vib_8191", 32'(vib_cnt), 7);
    tick_to(8192, 1);
    check("vib_8192", 32'(vib_cnt), 0);
    check("smp_wrap", 32'(dut.smp_cnt_q), 0);

    tick_to(12928, 1);
    check("trp_202", 32'(dut.tr_pos_q), 202);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_202", 32'(am_level), 1);
    am_dep = 1'b0;
    cyc(1'b1, 1'b0, 1'b0);
    check("am_202_shal", 32'(am_level), 0);
    am_dep = 1'b1;
    tick_to(13439, 1);
    check("trp_209", 32'(dut.tr_pos_q), 209);
    tick_to(13440, 1);
    check("trp_wrap", 32'(dut.tr_pos_q), 0);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_wrap", 32'(am_level), 0);
    check("smp_13440", 32'(dut.smp_cnt_q), 5248);

    rst_n = 1'b0;
    #1;
    check("rst2_smp", 32'(dut.smp_cnt_q), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ntick = 0;

    tick_to(5000, 1);
    check("smp_5000", 32'(dut.smp_cnt_q), 5000);
    check("vib_5000", 32'(vib_cnt), 4);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_5000", 32'(am_level), 19);
    cyc(1'b1, 1'b1, 1'b1);
    check("clr_smp", 32'(dut.smp_cnt_q), 0);
    check("clr_trp", 32'(dut.tr_pos_q), 0);
    check("clr_am", 32'(am_level), 0);
    check("clr_vib", 32'(vib_cnt), 0);
    repeat (3) cyc(1'b1, 1'b1, 1'b1);
    check("clr_hold", 32'(dut.smp_cnt_q), 0);
    cyc(1'b1, 1'b1, 1'b0);
    check("clr_resume", 32'(dut.smp_cnt_q), 1);
    ntick = 1;

    tick_to(2048, 1);
    check("vib_2048", 32'(vib_cnt), 2);
    cyc(1'b1, 1'b0, 1'b0);
    check("am_2048", 32'(am_level), 8);
    am_dep = 1'b0;
    repeat (100) cyc(1'b0, 1'b1, 1'b0);
    check("cen0_smp", 32'(dut.smp_cnt_q), 2048);
    check("cen0_vib", 32'(vib_cnt), 2);
    check("cen0_am", 32'(am_level), 8);
    am_dep = 1'b1;

    rst_n = 1'b0;
    #1;
    check("arst_vib", 32'(vib_cnt), 0);
    check("arst_am", 32'(am_level), 0);
    check("arst_trp", 32'(dut.tr_pos_q), 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30000; i++) begin
      @(negedge clk);
      cen = ($urandom_range(9) >= 3);
      zero = ($urandom_range(3) != 0);
      lfo_clr = ($urandom_range(1999) == 0);
      if ($urandom_range(199) == 0)
        am_dep = ~am_dep;
      @(posedge clk);
      #1;
      check("rnd_vib", 32'(vib_cnt), 32'(m_smp / 1024));
      check("rnd_am", 32'(am_level), 32'(m_am));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
